// File: rtl/scanport_cfg_sequencer_pkg.sv
// Shared definitions for the scanport configuration sequencer: state encoding,
// driver codes, legal VCCIO selects and the sequencing counter width.
package scanport_cfg_sequencer_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PARK     = 3'd1,
    ST_VCC_SET  = 3'd2,
    ST_VCC_WAIT = 3'd3,
    ST_APPLY    = 3'd4,
    ST_ACK      = 3'd5
  } state_e;

  localparam logic [2:0] PARK_CODE = 3'b011;
  localparam logic [5:0] PARK_WORD = {PARK_CODE, PARK_CODE};
  localparam logic [5:0] HIZ_WORD  = 6'b000000;

  localparam logic [2:0] VCCIO_OFF = 3'b000;
  localparam logic [2:0] VCCIO_1V5 = 3'b001;
  localparam logic [2:0] VCCIO_1V8 = 3'b010;
  localparam logic [2:0] VCCIO_2V5 = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ZERO = 16'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 16'd1;

  // Round-robin pointer value after reset: requester 0 wins the first tie.
  localparam logic PRIO_RESET = 1'b0;

  // At most one rail may be selected at a time.
  function automatic logic vccio_legal(input logic [2:0] v);
    logic ok;
    case (v)
      VCCIO_OFF, VCCIO_1V5, VCCIO_1V8, VCCIO_2V5: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/scanport_cfg_sequencer_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer moves past the requester that was
// just acknowledged.
module scanport_rr_arbiter
  import scanport_cfg_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_0,
  input  logic req_1,
  input  logic upd,
  input  logic upd_id,
  output logic gnt
);

  logic prio_r;

  // Grant selection: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    gnt = 1'b0;
    if (req_0 && req_1) begin
      gnt = prio_r;
    end else if (req_1) begin
      gnt = 1'b1;
    end else begin
      gnt = 1'b0;
    end
  end

  // Pointer register: favour the other requester after each acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_r <= PRIO_RESET;
    end else if (upd) begin
      prio_r <= ~upd_id;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/scanport_cfg_sequencer.sv
// Sequences driver-characteristic and VCCIO changes on two scanports: park the
// drivers, change the rail if needed, let it settle, then apply the new words.
module scanport_cfg_sequencer #(
  parameter int unsigned PARK_CYCLES       = 16,
  parameter int unsigned VCC_SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_0,
  input  logic       req_1,
  input  logic       port_0,
  input  logic       port_1,
  input  logic [5:0] char_a_0,
  input  logic [5:0] char_a_1,
  input  logic [5:0] char_b_0,
  input  logic [5:0] char_b_1,
  // Requester VCCIO selects are named vccio_sel_* so they stay distinct from
  // the per-port vccio_1/vccio_2 outputs.
  input  logic [2:0] vccio_sel_0,
  input  logic [2:0] vccio_sel_1,
  output logic       ack_0,
  output logic       ack_1,
  output logic [5:0] char_1a,
  output logic [5:0] char_1b,
  output logic [5:0] char_2a,
  output logic [5:0] char_2b,
  output logic [2:0] vccio_1,
  output logic [2:0] vccio_2,
  output logic       busy,
  output logic       err
);

  import scanport_cfg_sequencer_pkg::*;

  localparam logic [CNT_W-1:0] PARK_LOAD   = CNT_W'(PARK_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(VCC_SETTLE_CYCLES - 32'd1);

  state_e           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;

  logic       gnt_s, gnt_r, port_r;
  logic [5:0] a_r, b_r;
  logic [2:0] v_r;

  logic       req_any_s, port_in_s;
  logic [5:0] a_in_s, b_in_s;
  logic [2:0] v_in_s, v_sub_s, v_cur_s;
  logic       v_legal_s, ack_upd_s;
  logic       park_we_s, vcc_we_s, apply_we_s;

  logic       ack_0_r, ack_1_r, busy_r, err_r;
  logic [5:0] char_1a_r, char_1b_r, char_2a_r, char_2b_r;
  logic [2:0] vccio_1_r, vccio_2_r;

  assign ack_upd_s = (state_r == ST_ACK);

  scanport_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_0   (req_0),
    .req_1   (req_1),
    .upd     (ack_upd_s),
    .upd_id  (gnt_r),
    .gnt     (gnt_s)
  );

  // Request selection for the granted side and VCCIO substitution.
  always_comb begin
    req_any_s = req_0 | req_1;
    if (gnt_s) begin
      port_in_s = port_1;
      a_in_s    = char_a_1;
      b_in_s    = char_b_1;
      v_in_s    = vccio_sel_1;
    end else begin
      port_in_s = port_0;
      a_in_s    = char_a_0;
      b_in_s    = char_b_0;
      v_in_s    = vccio_sel_0;
    end
    v_legal_s = vccio_legal(v_r);
    if (v_legal_s) begin
      v_sub_s = v_r;
    end else begin
      v_sub_s = VCCIO_OFF;
    end
    if (port_r) begin
      v_cur_s = vccio_2_r;
    end else begin
      v_cur_s = vccio_1_r;
    end
  end

  // Next-state, counter and write-enable decode.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    park_we_s  = 1'b0;
    vcc_we_s   = 1'b0;
    apply_we_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          state_nx_s = ST_PARK;
          cnt_nx_s   = PARK_LOAD;
          park_we_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PARK: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = ST_VCC_SET;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      ST_VCC_SET: begin
        if (v_sub_s == v_cur_s) begin
          state_nx_s = ST_APPLY;
        end else begin
          state_nx_s = ST_VCC_WAIT;
          cnt_nx_s   = SETTLE_LOAD;
          vcc_we_s   = 1'b1;
        end
      end
      ST_VCC_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = ST_APPLY;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      ST_APPLY: begin
        state_nx_s = ST_ACK;
        apply_we_s = 1'b1;
      end
      ST_ACK: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Capture registers: frozen from the grant edge until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_r  <= 1'b0;
      port_r <= 1'b0;
      a_r    <= HIZ_WORD;
      b_r    <= HIZ_WORD;
      v_r    <= VCCIO_OFF;
    end else if (park_we_s) begin
      gnt_r  <= gnt_s;
      port_r <= port_in_s;
      a_r    <= a_in_s;
      b_r    <= b_in_s;
      v_r    <= v_in_s;
    end else begin
      gnt_r  <= gnt_r;
      port_r <= port_r;
      a_r    <= a_r;
      b_r    <= b_r;
      v_r    <= v_r;
    end
  end

  // Output registers; status flags follow the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_0_r   <= 1'b0;
      ack_1_r   <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      char_1a_r <= HIZ_WORD;
      char_1b_r <= HIZ_WORD;
      char_2a_r <= HIZ_WORD;
      char_2b_r <= HIZ_WORD;
      vccio_1_r <= VCCIO_OFF;
      vccio_2_r <= VCCIO_OFF;
    end else begin
      ack_0_r <= (state_nx_s == ST_ACK) && !gnt_r;
      ack_1_r <= (state_nx_s == ST_ACK) && gnt_r;
      busy_r  <= (state_nx_s != ST_IDLE);
      err_r   <= (state_nx_s == ST_VCC_SET) && !v_legal_s;
      if (park_we_s) begin
        if (port_in_s) begin
          char_2a_r <= PARK_WORD;
          char_2b_r <= PARK_WORD;
        end else begin
          char_1a_r <= PARK_WORD;
          char_1b_r <= PARK_WORD;
        end
      end else if (apply_we_s) begin
        if (port_r) begin
          char_2a_r <= a_r;
          char_2b_r <= b_r;
        end else begin
          char_1a_r <= a_r;
          char_1b_r <= b_r;
        end
      end else begin
        char_1a_r <= char_1a_r;
        char_1b_r <= char_1b_r;
        char_2a_r <= char_2a_r;
        char_2b_r <= char_2b_r;
      end
      if (vcc_we_s) begin
        if (port_r) begin
          vccio_2_r <= v_sub_s;
        end else begin
          vccio_1_r <= v_sub_s;
        end
      end else begin
        vccio_1_r <= vccio_1_r;
        vccio_2_r <= vccio_2_r;
      end
    end
  end

  assign ack_0   = ack_0_r;
  assign ack_1   = ack_1_r;
  assign busy    = busy_r;
  assign err     = err_r;
  assign char_1a = char_1a_r;
  assign char_1b = char_1b_r;
  assign char_2a = char_2a_r;
  assign char_2b = char_2b_r;
  assign vccio_1 = vccio_1_r;
  assign vccio_2 = vccio_2_r;

endmodule

// File: tb/tb_scanport_cfg_sequencer.sv
// Directed bench for scanport_cfg_sequencer with an expected-result queue
// filled at request time and drained on each acknowledge.
module tb_scanport_cfg_sequencer;

  localparam int P = 16;
  localparam int S = 1024;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_0 = 1'b0, req_1 = 1'b0;
  logic       port_0 = 1'b0, port_1 = 1'b0;
  logic [5:0] char_a_0 = 6'd0, char_a_1 = 6'd0, char_b_0 = 6'd0, char_b_1 = 6'd0;
  logic [2:0] vccio_sel_0 = 3'd0, vccio_sel_1 = 3'd0;
  logic       ack_0, ack_1, busy, err;
  logic [5:0] char_1a, char_1b, char_2a, char_2b;
  logic [2:0] vccio_1, vccio_2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         id;
    bit         port;
    int         lat;
    int         err_n;
    logic [5:0] c1a, c1b, c2a, c2b;
    logic [2:0] v1, v2;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] m_a[2];
  logic [5:0] m_b[2];
  logic [2:0] m_v[2];

  always #5 clk = ~clk;

  scanport_cfg_sequencer #(.PARK_CYCLES(P), .VCC_SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .req_1(req_1), .port_0(port_0), .port_1(port_1),
    .char_a_0(char_a_0), .char_a_1(char_a_1), .char_b_0(char_b_0), .char_b_1(char_b_1),
    .vccio_sel_0(vccio_sel_0), .vccio_sel_1(vccio_sel_1),
    .ack_0(ack_0), .ack_1(ack_1),
    .char_1a(char_1a), .char_1b(char_1b), .char_2a(char_2a), .char_2b(char_2b),
    .vccio_1(vccio_1), .vccio_2(vccio_2), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_c1a"}, 32'(char_1a), 32'd0);
    chk({tag, "_c1b"}, 32'(char_1b), 32'd0);
    chk({tag, "_c2a"}, 32'(char_2a), 32'd0);
    chk({tag, "_c2b"}, 32'(char_2b), 32'd0);
    chk({tag, "_v1"}, 32'(vccio_1), 32'd0);
    chk({tag, "_v2"}, 32'(vccio_2), 32'd0);
    chk({tag, "_ack"}, 32'({ack_1, ack_0}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_a[i] = 6'd0;
      m_b[i] = 6'd0;
      m_v[i] = 3'd0;
    end
  endtask

  // Drive one requester and queue the outcome its sequence must produce.
  task automatic drive(input bit id, input bit port, input logic [5:0] a, input logic [5:0] b,
                       input logic [2:0] v);
    exp_t e;
    logic [2:0] vs;
    bit legal;
    if (id) begin
      port_1 = port; char_a_1 = a; char_b_1 = b; vccio_sel_1 = v; req_1 = 1'b1;
    end else begin
      port_0 = port; char_a_0 = a; char_b_0 = b; vccio_sel_0 = v; req_0 = 1'b1;
    end
    legal = (v == 3'b000) || (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    vs = legal ? v : 3'b000;
    e.id = id;
    e.port = port;
    e.err_n = legal ? 0 : 1;
    e.lat = P + 3 + ((vs != m_v[port]) ? S : 0);
    m_a[port] = a;
    m_b[port] = b;
    m_v[port] = vs;
    e.c1a = m_a[0]; e.c1b = m_b[0]; e.c2a = m_a[1]; e.c2b = m_b[1];
    e.v1 = m_v[0]; e.v2 = m_v[1];
    sb_q.push_back(e);
  endtask

  // Wait for the next acknowledge (the first edge is the capture edge) and
  // compare it with the oldest queued expectation.
  task automatic wait_ack(input bit mutate, input bit keep_req);
    exp_t e;
    int n, errs;
    bit got;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    n = 0; errs = 0; got = 1'b0;
    while (!got && n < e.lat + 50) begin
      @(posedge clk);
      n++;
      #1;
      if (err) errs++;
      if (n == 1) begin
        chk("park_a", 32'(e.port ? char_2a : char_1a), 32'o33);
        chk("park_b", 32'(e.port ? char_2b : char_1b), 32'o33);
        chk("busy_run", 32'(busy), 32'd1);
        if (mutate && e.id) begin
          req_1 = 1'b0; char_a_1 = ~char_a_1; char_b_1 = ~char_b_1; vccio_sel_1 = 3'b111; port_1 = ~port_1;
        end else if (mutate) begin
          req_0 = 1'b0; char_a_0 = ~char_a_0; char_b_0 = ~char_b_0; vccio_sel_0 = 3'b111; port_0 = ~port_0;
        end
      end
      if (ack_0 || ack_1) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", n, e.lat);
    chk("ack_0", 32'(ack_0), 32'(!e.id));
    chk("ack_1", 32'(ack_1), 32'(e.id));
    chk("char_1a", 32'(char_1a), 32'(e.c1a));
    chk("char_1b", 32'(char_1b), 32'(e.c1b));
    chk("char_2a", 32'(char_2a), 32'(e.c2a));
    chk("char_2b", 32'(char_2b), 32'(e.c2b));
    chk("vccio_1", 32'(vccio_1), 32'(e.v1));
    chk("vccio_2", 32'(vccio_2), 32'(e.v2));
    chk("err_pulses", errs, e.err_n);
    if (!keep_req && e.id) req_1 = 1'b0;
    else if (!keep_req) req_0 = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_one_cycle", 32'({ack_1, ack_0}), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request with a rail change, then a repeat on the same rail with
    // the request dropped and inputs scrambled right after capture.
    drive(1'b0, 1'b0, 6'o66, 6'o66, 3'b001);
    wait_ack(1'b0, 1'b0);
    drive(1'b0, 1'b0, 6'o12, 6'o45, 3'b001);
    wait_ack(1'b1, 1'b0);

    // Port 2 rail change, then an illegal select that falls back to 000.
    drive(1'b1, 1'b1, 6'o21, 6'o54, 3'b100);
    wait_ack(1'b0, 1'b0);
    drive(1'b1, 1'b1, 6'o07, 6'o70, 3'b011);
    wait_ack(1'b0, 1'b0);

    // Reset while the rail is settling: immediate clear, no acknowledge.
    drive(1'b0, 1'b0, 6'o55, 6'o22, 3'b010);
    void'(sb_q.pop_back());
    for (int i = 0; i < P + 10; i++) begin
      @(posedge clk);
      #1;
      chk("no_ack_pre_rst", 32'({ack_1, ack_0}), 32'd0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    req_0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("held_rst");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("no_ack_post_rst", 32'({ack_1, ack_0}), 32'd0);
    drive(1'b1, 1'b0, 6'o13, 6'o31, 3'b100);
    wait_ack(1'b0, 1'b0);

    // Contention twice: both raised together, grant order 0,1 each time.
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 1'b0, 6'o44 ^ 6'(r), 6'o55, 3'b100);
      drive(1'b1, 1'b1, 6'o03 ^ 6'(r), 6'o30, 3'b000);
      wait_ack(1'b0, 1'b0);
      wait_ack(1'b0, 1'b0);
    end

    // After a lone grant to 0 the tie goes to 1; a held req_1 re-requests.
    drive(1'b0, 1'b0, 6'o36, 6'o63, 3'b100);
    wait_ack(1'b0, 1'b0);
    drive(1'b1, 1'b1, 6'o17, 6'o71, 3'b000);
    drive(1'b0, 1'b0, 6'o27, 6'o72, 3'b100);
    wait_ack(1'b0, 1'b1);
    drive(1'b1, 1'b1, 6'o17, 6'o71, 3'b000);
    wait_ack(1'b0, 1'b0);
    wait_ack(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scanport_cfg_sequencer.md
SCANPORT_CFG_SEQUENCER -- requirements
Module: scanport_cfg_sequencer

Interface
REQ-001 Parameter PARK_CYCLES, default 16: TCK/TMS/TDO/TRST high-z dwell before any VCCIO change, in clk cycles; legal range 1..65535.
REQ-002 Parameter VCC_SETTLE_CYCLES, default 1024: wait after a VCCIO change before drivers re-enable, in clk cycles; legal range 1..65535.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_0, req_1  in  1 each  level request from requester 0 / 1; held until the matching ack.
REQ-007 port_0, port_1  in  1 each  target scanport per requester (0 = port 1, 1 = port 2).
REQ-008 char_a_0, char_a_1  in  6 each  requested TCK[2:0] / TMS[5:3] driver codes.
REQ-009 char_b_0, char_b_1  in  6 each  requested TDO[2:0] / TRST[5:3] driver codes.
REQ-010 vccio_0, vccio_1  in  3 each  requested {P2V5, P1V8, P1V5} select.
REQ-011 ack_0, ack_1  out  1 each  one-cycle completion pulse to the granted requester.
REQ-012 char_1a, char_1b, char_2a, char_2b  out  6 each  driver-characteristic words to the scanport drivers.
REQ-013 vccio_1, vccio_2  out  3 each  VCCIO select per port.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 err  out  1  one-cycle pulse when an illegal VCCIO request is captured.

Function
REQ-016 FSM states: IDLE, PARK, VCC_SET, VCC_WAIT, APPLY, ACK.
REQ-017 IDLE: with any req high, grant one requester, capture its port, char_a, char_b and vccio into holding registers, and go to PARK on the next edge.
REQ-018 Arbitration, single request: the requesting side is granted.
REQ-019 Arbitration, both requesting: grant the requester not granted last (round-robin); the pointer favours requester 0 after reset.
REQ-020 PARK entry: write 6'b011011 to both char words of the captured port and load the counter with PARK_CYCLES-1.
REQ-021 PARK: decrement the counter each cycle; at 0, go to VCC_SET. Dwell is exactly PARK_CYCLES cycles.
REQ-022 VCCIO legality: legal values are 000, 001, 010, 100.
REQ-023 Illegal captured VCCIO (more than one bit set): substitute 000 and pulse err in the VCC_SET cycle.
REQ-024 VCC_SET, VCCIO unchanged: if the (substituted) VCCIO equals the port's current vccio, go directly to APPLY.
REQ-025 VCC_SET, VCCIO changed: write the new vccio, load the counter with VCC_SETTLE_CYCLES-1, and go to VCC_WAIT.
REQ-026 VCC_WAIT: decrement the counter; at 0, go to APPLY.
REQ-027 APPLY: write the captured char_a and char_b to the captured port, then go to ACK.
REQ-028 ACK: assert the granted requester's ack for exactly one cycle, update the round-robin pointer, and return to IDLE.
REQ-029 Untargeted port: its outputs never change during a sequence.
REQ-030 Request handling: a req dropped after capture does not abort; the sequence completes and ack still pulses.
REQ-031 A req still high in the IDLE cycle after ack is treated as a new request.
REQ-032 Captured data is immune to input changes after the IDLE capture edge.
REQ-033 Counters are 16 bit; no wrap occurs within the legal parameter ranges.

Reset
REQ-034 Reset values: char words 6'b000000 (drivers high-z), vccio 3'b000, ack 0, err 0, busy 0, state IDLE, round-robin pointer favouring requester 0, counters 0.
REQ-035 reset_n assertion mid-sequence aborts immediately, with no ack for the aborted request.

Structure
REQ-036 Shared package contents: FSM state encoding, PARK code 3'b011, legal VCCIO codes, counter width 16.
REQ-037 Sub-module scanport_rr_arbiter: 2-way round-robin grant with pointer update on ack; all else is in the top module.

Verification
REQ-038 Single request: req_0, port 0, char_a 6'o66, char_b 6'o66, vccio 001 from reset -> char_1a 6'o33 for 16 cycles, vccio_1 = 001, then 1024 cycles later char_1a/1b = 6'o66, then one ack_0 pulse; port 2 untouched.
REQ-039 Same VCCIO: repeat the request with vccio 001 -> no VCC_WAIT; ack_0 arrives PARK_CYCLES+3 cycles after capture.
REQ-040 Contention: req_0 and req_1 asserted in the same cycle, twice -> grant order 0, 1, 0, 1; acks never overlap.
REQ-041 Illegal VCCIO: vccio 011 -> err pulses once; vccio_x = 000; sequence completes with ack.
REQ-042 Reset mid-sequence: reset_n low during VCC_WAIT -> all outputs at reset values asynchronously; no ack; new request after release proceeds normally.
